// File: rtl/adder_digit_serial_if.sv
// Handshake bundle for adder_digit_serial: operand request channel, result
// channel and status, with a producer/consumer (master) view and a block (slave) view.
interface adder_digit_serial_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             V;
    logic             busy;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, S, Cout, V, busy
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, S, Cout, V, busy
    );
endinterface

// File: rtl/adder_digit_serial.sv
// Digit-serial adder/subtractor: WIDTH-bit operands summed DIGIT bits per cycle,
// LSB digit first, with a registered carry between digits and a held result.
module adder_digit_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_digit_serial_if.slave  bus
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   s_q;
    logic               cout_q;
    logic               v_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [DIGIT-1:0]   a_dig_d;
    logic [DIGIT-1:0]   b_dig_d;
    logic [DIGIT-1:0]   dig_sum_d;
    logic               dig_carry_d;
    logic               msb_carry_in_d;
    logic               last_dig_d;
    logic [WIDTH-1:0]   s_d;

    // Select the digit of each stored operand addressed by the digit counter
    always_comb begin
        a_dig_d = {DIGIT{1'b0}};
        b_dig_d = {DIGIT{1'b0}};
        for (int i = 0; i < NDIG; i++) begin
            a_dig_d = (cnt_q == CNT_W'(i)) ? a_q[i*DIGIT +: DIGIT] : a_dig_d;
            b_dig_d = (cnt_q == CNT_W'(i)) ? b_q[i*DIGIT +: DIGIT] : b_dig_d;
        end
    end

    // One digit of the ripple: the only adder in the block
    always_comb begin
        {dig_carry_d, dig_sum_d} = {1'b0, a_dig_d} + {1'b0, b_dig_d} + {{DIGIT{1'b0}}, carry_q};
        // Carry into the top bit of the digit recovered from the sum bit itself
        msb_carry_in_d = a_dig_d[DIGIT-1] ^ b_dig_d[DIGIT-1] ^ dig_sum_d[DIGIT-1];
        last_dig_d     = (cnt_q == CNT_W'(NDIG - 1));
    end

    // Merge the freshly computed digit into the result word
    always_comb begin
        s_d = s_q;
        for (int i = 0; i < NDIG; i++) begin
            s_d[i*DIGIT +: DIGIT] = (cnt_q == CNT_W'(i)) ? dig_sum_d : s_q[i*DIGIT +: DIGIT];
        end
    end

    // Control FSM together with every piece of datapath state it owns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            carry_q     <= 1'b0;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            s_q         <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction becomes A + ~B + ~Bin, so Cout reads as "no borrow"
                        a_q     <= bus.A;
                        b_q     <= bus.B ^ {WIDTH{bus.Sub}};
                        carry_q <= bus.Cin ^ bus.Sub;
                        cnt_q   <= {CNT_W{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= ST_BUSY;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    s_q     <= s_d;
                    carry_q <= dig_carry_d;
                    if (last_dig_d) begin
                        cout_q      <= dig_carry_d;
                        v_q         <= msb_carry_in_d ^ dig_carry_d;
                        cnt_q       <= {CNT_W{1'b0}};
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    cnt_q       <= {CNT_W{1'b0}};
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE) & rst_n;
    assign bus.out_valid = out_valid_q;
    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.V         = v_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_adder_digit_serial.sv
// Bench for adder_digit_serial: three 8-bit instances (DIGIT=4, 8, 1) driven
// through a scoreboard of expected results built from a reference arithmetic model.
module tb_adder_digit_serial;

    localparam int W    = 8;
    localparam int NDUT = 3;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    int   ndig[NDUT] = '{2, 1, 8};

    logic         iv[NDUT];
    logic [W-1:0] ta[NDUT];
    logic [W-1:0] tbv[NDUT];
    logic         tcin[NDUT];
    logic         tsub[NDUT];
    logic         ordy[NDUT];
    logic         ir[NDUT];
    logic         ov[NDUT];
    logic [W-1:0] s[NDUT];
    logic         cout[NDUT];
    logic         v[NDUT];
    logic         bsy[NDUT];

    adder_digit_serial_if #(.WIDTH(W)) bus4 ();
    adder_digit_serial_if #(.WIDTH(W)) bus8 ();
    adder_digit_serial_if #(.WIDTH(W)) bus1 ();

    adder_digit_serial #(.WIDTH(W), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    adder_digit_serial #(.WIDTH(W), .DIGIT(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    adder_digit_serial #(.WIDTH(W), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

`define TB_HOOK(IDX, BUS) \
    assign BUS.in_valid  = iv[IDX];   \
    assign BUS.A         = ta[IDX];   \
    assign BUS.B         = tbv[IDX];  \
    assign BUS.Cin       = tcin[IDX]; \
    assign BUS.Sub       = tsub[IDX]; \
    assign BUS.out_ready = ordy[IDX]; \
    assign ir[IDX]       = BUS.in_ready;  \
    assign ov[IDX]       = BUS.out_valid; \
    assign s[IDX]        = BUS.S;     \
    assign cout[IDX]     = BUS.Cout;  \
    assign v[IDX]        = BUS.V;     \
    assign bsy[IDX]      = BUS.busy;

    `TB_HOOK(0, bus4)
    `TB_HOOK(1, bus8)
    `TB_HOOK(2, bus1)

    // Reference: plain 9-bit arithmetic; for subtraction Cout is the inverted borrow
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W:0] full;
        exp_t       e;
        if (sub) begin
            full   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
            e.s    = full[W-1:0];
            e.cout = ~full[W];
            e.v    = (a[W-1] != b[W-1]) && (e.s[W-1] != a[W-1]);
        end else begin
            full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            e.s    = full[W-1:0];
            e.cout = full[W];
            e.v    = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
        end
        return e;
    endfunction

    task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input int stall, input string tag);
        exp_t exp;
        exp_t got;
        int   t;
        @(negedge clk);
        t = 0;
        while (!ir[idx] && t < 64) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (ir[idx] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept_timeout: in_ready=%b required 1", tag, ir[idx]);
            return;
        end
        ta[idx] = a; tbv[idx] = b; tcin[idx] = cin; tsub[idx] = sub; iv[idx] = 1'b1;
        sb.push_back(model(a, b, cin, sub));
        @(posedge clk); #1;
        iv[idx]   = 1'b0;
        ta[idx]   = W'($urandom);
        tbv[idx]  = W'($urandom);
        tcin[idx] = 1'($urandom_range(0, 1));
        tsub[idx] = 1'($urandom_range(0, 1));
        n_tests++;
        if (ir[idx] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s in_ready_after_accept: got %b required 0", tag, ir[idx]);
        end
        t = 0;
        while (ov[idx] !== 1'b1 && t < 64) begin
            @(posedge clk); #1;
            t++;
        end
        exp = sb.pop_front();
        n_tests++;
        if (t != ndig[idx]) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles required %0d", tag, t, ndig[idx]);
        end
        got = {s[idx], cout[idx], v[idx]};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s result A=%h B=%h Cin=%b Sub=%b: got S=%h Cout=%b V=%b required S=%h Cout=%b V=%b",
                     tag, a, b, cin, sub, got.s, got.cout, got.v, exp.s, exp.cout, exp.v);
        end
        for (int c = 0; c < stall; c++) begin
            @(posedge clk); #1;
            got = {s[idx], cout[idx], v[idx]};
            n_tests++;
            if (ov[idx] !== 1'b1 || got !== exp) begin
                n_fail++;
                $display("FAIL %s stall_hold: out_valid=%b S=%h Cout=%b V=%b required 1 %h %b %b",
                         tag, ov[idx], got.s, got.cout, got.v, exp.s, exp.cout, exp.v);
            end
        end
        ordy[idx] = 1'b1;
        @(posedge clk); #1;
        ordy[idx] = 1'b0;
        n_tests++;
        if (ov[idx] !== 1'b0 || ir[idx] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s release: out_valid=%b in_ready=%b required 0 1", tag, ov[idx], ir[idx]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            iv[i] = 1'b0; ta[i] = 8'h00; tbv[i] = 8'h00;
            tcin[i] = 1'b0; tsub[i] = 1'b0; ordy[i] = 1'b0;
        end
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            n_tests++;
            if ({ov[i], ir[i], bsy[i], s[i], cout[i], v[i]} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: ov=%b ir=%b busy=%b S=%h Cout=%b V=%b required all 0",
                         i, ov[i], ir[i], bsy[i], s[i], cout[i], v[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            n_tests++;
            if (ir[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_release dut%0d: in_ready=%b required 1", i, ir[i]);
            end
        end
    endtask

    task automatic test_add();
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, "add_ff_01");
        run_op(0, 8'h7F, 8'h01, 1'b1, 1'b0, 1, "overflow_7f_01");
    endtask

    task automatic test_subtract();
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 0, "sub_05_07");
        run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 2, "sub_80_01");
        run_op(0, 8'h00, 8'h00, 1'b1, 1'b1, 0, "sub_borrow_in");
    endtask

    task automatic test_backpressure();
        exp_t exp;
        exp_t got;
        int   t;
        @(negedge clk);
        ta[0] = 8'h3C; tbv[0] = 8'hC5; tcin[0] = 1'b1; tsub[0] = 1'b0; iv[0] = 1'b1;
        sb.push_back(model(8'h3C, 8'hC5, 1'b1, 1'b0));
        @(posedge clk); #1;
        iv[0] = 1'b0;
        t = 0;
        while (ov[0] !== 1'b1 && t < 64) begin
            @(posedge clk); #1;
            t++;
        end
        exp = sb.pop_front();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            iv[0] = 1'($urandom_range(0, 1)); ta[0] = W'($urandom); tbv[0] = W'($urandom);
            @(posedge clk); #1;
            got = {s[0], cout[0], v[0]};
            n_tests++;
            if (got !== exp || ov[0] !== 1'b1 || ir[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold: S=%h Cout=%b V=%b ov=%b ir=%b required %h %b %b 1 0",
                         got.s, got.cout, got.v, ov[0], ir[0], exp.s, exp.cout, exp.v);
            end
        end
        @(negedge clk);
        iv[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        n_tests++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: ov=%b ir=%b required 0 1", ov[0], ir[0]);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_no_queue: ov=%b busy=%b required 0 0", ov[0], bsy[0]);
        end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        ta[0] = 8'hF0; tbv[0] = 8'h0F; tcin[0] = 1'b1; tsub[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        n_tests++;
        if (bsy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy_entry: busy=%b required 1", bsy[0]);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ov[0], ir[0], bsy[0], s[0], cout[0], v[0]} !== 13'd0) begin
            n_fail++;
            $display("FAIL mid_busy_reset: ov=%b ir=%b busy=%b S=%h Cout=%b V=%b required all 0",
                     ov[0], ir[0], bsy[0], s[0], cout[0], v[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy_no_result: ov=%b ir=%b required 0 1", ov[0], ir[0]);
        end
        run_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 0, "after_reset_12_34");
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 8'hFF;
            1:       return 8'h80;
            2:       return 8'h7F;
            3:       return 8'h00;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic test_sweep(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            run_op(idx, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "sweep");
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_op(0, W'(8'h11 * i), W'(8'hF0 - 8'h20 * i), 1'(i % 2), 1'(i / 3), 0, "back_to_back");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_subtract();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        test_sweep(1, 1000);
        test_sweep(2, 1000);
        test_sweep(0, 200);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
